// File: rtl/key_rot_reg.sv
// ============================================================================
// Module      : key_rot_reg
// Description : Key register with manual rotate ops and a fixed-length
//               auto-run of left rotations. Bit 0 of x/y is the MSB.
//               Optional macro KEY_ROT_RC_EN XORs (round+1) into the LSBs
//               of each auto-run step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_rot_reg #(
    parameter int WIDTH  = 64,
    parameter int ROT_A  = 16,
    parameter int ROT_B  = 5,
    parameter int ROUNDS = 10,
    localparam int CW    = $clog2(ROUNDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [0:WIDTH-1] x,
    input  logic [1:0]       op,
    input  logic             start,
    output logic [0:WIDTH-1] y,
    output logic [CW-1:0]    round,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned ROT_A_M = ROT_A % WIDTH;
    localparam int unsigned ROT_B_M = ROT_B % WIDTH;
    // A right rotate by n is a left rotate by WIDTH-n.
    localparam int unsigned ROT_R_M = (WIDTH - ROT_B_M) % WIDTH;

    localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CW-1:0]    round_q, round_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_val;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v,
                                              input int unsigned n);
        if (n == 0)
            return v;
        return (v << n) | (v >> (WIDTH - n));
    endfunction

`ifdef KEY_ROT_RC_EN
    assign step_val = rotl(y_q, ROT_A_M) ^ {{(WIDTH-CW){1'b0}}, round_q + 1'b1};
`else
    assign step_val = rotl(y_q, ROT_A_M);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            y_q     <= y_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        round_d = round_q;
        busy_d  = busy_q;
        done_d  = done_q;

        if (ld) begin
            state_d = IDLE;
            y_d     = x;
            round_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        round_d = '0;
                        busy_d  = 1'b1;
                    end else begin
                        case (op)
                            2'b01:   y_d = rotl(y_q, ROT_A_M);
                            2'b10:   y_d = rotl(y_q, ROT_B_M);
                            2'b11:   y_d = rotl(y_q, ROT_R_M);
                            default: y_d = y_q;
                        endcase
                    end
                end
                RUN: begin
                    y_d     = step_val;
                    round_d = round_q + 1'b1;
                    if (round_q == LAST_ROUND) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                DONE: begin
                    // round stays at ROUNDS unless a restart clears it.
                    done_d = 1'b0;
                    if (start) begin
                        state_d = RUN;
                        round_d = '0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    assign y     = y_q;
    assign round = round_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_key_rot_reg.sv
// ============================================================================
// Module      : tb_key_rot_reg
// Description : Directed self-checking bench for key_rot_reg (ROUNDS=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_rot_reg;

    localparam int WIDTH  = 64;
    localparam int ROUNDS = 4;
    localparam int CW     = $clog2(ROUNDS + 1);

    localparam logic [63:0] X0 = 64'h1234_5678_9abc_def0;
    localparam logic [63:0] R1 = 64'h5678_9abc_def0_1234;
`ifdef KEY_ROT_RC_EN
    localparam logic [63:0] S1 = 64'h5678_9abc_def0_1235;
    localparam logic [63:0] S2 = 64'h9abc_def0_1235_567a;
    localparam logic [63:0] S3 = 64'hdef0_1235_567a_9abf;
    localparam logic [63:0] S4 = 64'h1235_567a_9abf_def4;
`else
    localparam logic [63:0] S1 = 64'h5678_9abc_def0_1234;
    localparam logic [63:0] S2 = 64'h9abc_def0_1234_5678;
    localparam logic [63:0] S3 = 64'hdef0_1234_5678_9abc;
    localparam logic [63:0] S4 = X0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b1;
    logic             ld = 1'b0;
    logic [0:WIDTH-1] x = '0;
    logic [1:0]       op = 2'b00;
    logic             start = 1'b0;
    logic [0:WIDTH-1] y;
    logic [CW-1:0]    round;
    logic             busy;
    logic             done;

    int n_total = 0;
    int n_bad   = 0;

    key_rot_reg #(
        .WIDTH (WIDTH),
        .ROT_A (16),
        .ROT_B (5),
        .ROUNDS(ROUNDS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .ld   (ld),
        .x    (x),
        .op   (op),
        .start(start),
        .y    (y),
        .round(round),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [63:0] ey, input int er,
                           input logic eb, input logic ed);
        chk({tag, ".y"}, y, ey);
        chk({tag, ".round"}, 64'(round), 64'(er));
        chk({tag, ".busy"}, 64'(busy), 64'(eb));
        chk({tag, ".done"}, 64'(done), 64'(ed));
    endtask

    task automatic load(input logic [63:0] v);
        ld = 1'b1; x = v;
        tick();
        ld = 1'b0;
    endtask

    initial begin
        // reset
        tick(); tick();
        rst = 1'b0;
        chk_all("reset", 64'h0, 0, 1'b0, 1'b0);

        // manual ops
        load(X0);
        chk("load", y, X0);
        op = 2'b01; tick();
        chk("op01", y, R1);
        op = 2'b00; tick(); tick();
        chk("op00_hold", y, R1);
        load(X0); op = 2'b10; tick(); op = 2'b00;
        chk("op10", y, 64'h468a_cf13_579b_de02);
        load(X0); op = 2'b11; tick(); op = 2'b00;
        chk("op11", y, 64'h8091_a2b3_c4d5_e6f7);

        // full auto-run; op held nonzero to show it is ignored while running
        load(X0);
        start = 1'b1; tick(); start = 1'b0; op = 2'b10;
        chk_all("run_N", X0, 0, 1'b1, 1'b0);
        tick(); chk_all("run_s1", S1, 1, 1'b1, 1'b0);
        tick(); chk_all("run_s2", S2, 2, 1'b1, 1'b0);
        tick(); chk_all("run_s3", S3, 3, 1'b1, 1'b0);
        op = 2'b00;
        tick(); chk_all("run_done", S4, 4, 1'b0, 1'b1);
        tick(); chk_all("run_idle", S4, 4, 1'b0, 1'b0);

        // en=0 freeze mid-run; ld/start/op ignored while frozen
        load(X0);
        start = 1'b1; tick(); start = 1'b0;
        tick(); chk_all("frz_s1", S1, 1, 1'b1, 1'b0);
        en = 1'b0; ld = 1'b1; op = 2'b01; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("frz_hold", S1, 1, 1'b1, 1'b0);
        end
        en = 1'b1; ld = 1'b0; op = 2'b00; start = 1'b0;
        tick(); chk_all("frz_s2", S2, 2, 1'b1, 1'b0);
        tick(); tick(); chk_all("frz_done", S4, 4, 1'b0, 1'b1);
        // done held across disabled cycles
        en = 1'b0; tick(); tick();
        chk_all("done_hold", S4, 4, 1'b0, 1'b1);
        // restart from DONE
        en = 1'b1; start = 1'b1; tick(); start = 1'b0;
        chk_all("restart", S4, 0, 1'b1, 1'b0);

        // ld aborts at step 2
        load(X0);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); chk("abort_pre.round", 64'(round), 64'd2);
        load(X0);
        chk_all("abort", X0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk_all("abort_nodone", X0, 0, 1'b0, 1'b0);

        // rst at step 2, asserted with en=0 to show rst wins
        load(X0);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        en = 1'b0; rst = 1'b1; tick(); rst = 1'b0; en = 1'b1;
        chk_all("rst_mid", 64'h0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_rot_reg.md
KEY_ROT_REG -- requirements
Module: key_rot_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 64: register width; bit 0 is MSB.
REQ-002 SHALL have parameter ROT_A, default 16: left-rotate amount for op 01 and for auto-run steps.
REQ-003 SHALL have parameter ROT_B, default 5: rotate amount for ops 10 and 11.
REQ-004 SHALL have parameter ROUNDS, default 10, minimum 1: auto-run step count.
REQ-005 SHALL have derived parameter CW = clog2(ROUNDS+1): round counter width.
REQ-006 SHALL have port clk, input, 1: the block's one clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port en, input, 1: global clock enable.
REQ-009 SHALL have port ld, input, 1: load x into register.
REQ-010 SHALL have port x, input, [0:WIDTH-1]: load data.
REQ-011 SHALL have port op, input, 2: manual op (00 hold, 01 rotl ROT_A, 10 rotl ROT_B, 11 rotr ROT_B).
REQ-012 SHALL have port start, input, 1: begin auto-run.
REQ-013 SHALL have port y, output, [0:WIDTH-1]: register contents.
REQ-014 SHALL have port round, output, CW: completed auto-run steps.
REQ-015 SHALL have port busy, output, 1: high while in RUN.
REQ-016 SHALL have port done, output, 1: one-cycle pulse in DONE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE; all outputs are registered.
REQ-018 SHALL, with en=0 and rst=0, freeze all state and outputs and ignore ld, start and op.
REQ-019 SHALL, on each edge with en=1, evaluate priority ld > start > op.
REQ-020 SHALL, on ld with en=1 in any state: y<=x, round<=0, state<=IDLE, busy<=0, done<=0; an in-progress run aborts.
REQ-021 SHALL, in IDLE with start=1: state<=RUN, round<=0, busy<=1; y unchanged; op ignored.
REQ-022 SHALL, in IDLE with no ld or start, apply op to y.
REQ-023 SHALL, on each en=1 edge in RUN: y<=rotl(y,ROT_A), round<=round+1; op and start ignored.
REQ-024 SHALL, on the RUN edge where round becomes ROUNDS: state<=DONE, busy<=0, done<=1.
REQ-025 SHALL make DONE last exactly one enabled cycle, then go to IDLE with done<=0.
REQ-026 SHALL keep round at ROUNDS after DONE until the next ld, start or rst.
REQ-027 SHALL, on start with en=1 in DONE, behave as in IDLE (restart), with done<=0.
REQ-028 SHALL reduce rotate amounts mod WIDTH; an amount of 0 yields identity.
REQ-029 SHALL, per REQ-018, hold done high across en=0 cycles; the done pulse ends only on an en=1 edge.

Reset
REQ-030 SHALL give rst priority over en and all other inputs.
REQ-031 SHALL, on rst: y=0, round=0, busy=0, done=0, state=IDLE, including mid-run.

Configuration
REQ-032 SHALL, when KEY_ROT_RC_EN is defined, XOR each RUN step's result with the value round+1 placed in bits WIDTH-CW..WIDTH-1, with all other bits zero.
REQ-033 SHALL, when KEY_ROT_RC_EN is undefined, make RUN steps pure rotation.

Verification (WIDTH=64, x=64'h1234_5678_9abc_def0)
REQ-034 SHALL cover ld then op=01 for one cycle -> y=64'h5678_9abc_def0_1234; then op=00 -> y held.
REQ-035 SHALL cover ld, op=10 -> y=64'h468a_cf13_579b_de02; ld, op=11 -> y=64'h8091_a2b3_c4d5_e6f7.
REQ-036 SHALL cover ROUNDS=4, macro off, ld then start at edge N -> busy=1 at edges N..N+3, round=4 and done=1 for one cycle after edge N+4, y=x, then IDLE.
REQ-037 SHALL cover en=0 for 3 cycles mid-run -> y, round and busy frozen; run completion is delayed by 3 cycles.
REQ-038 SHALL cover ld asserted at run step 2 -> y=x, round=0, busy=0, no done pulse; rst at step 2 -> all outputs 0.
REQ-039 SHALL cover ROUNDS=4 with KEY_ROT_RC_EN defined -> after step 1, y=64'h5678_9abc_def0_1235, and done timing is unchanged.
